// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - instruction fetch with direct-mapped one-word-line I-cache and single-outstanding memory refill
module instruction_fetch #(
    parameter int          ICACHE_IDX_W = 5,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,
    input  logic [31:0] jump_pc,
    input  logic        queue_is_full,
    output logic        IF_inst_valid,
    output logic [31:0] IF_inst,
    output logic [31:0] IF_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data
);

    localparam int LINES = 1 << ICACHE_IDX_W;
    localparam int TAG_W = 32 - ICACHE_IDX_W - 2;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    logic [ICACHE_IDX_W-1:0] pc_idx;
    logic [TAG_W-1:0]        pc_tag;
    logic [ICACHE_IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0]        fill_tag;
    logic                    hit;
    logic                    fill_we;

    assign pc_idx   = pc_q[ICACHE_IDX_W+1:2];
    assign pc_tag   = pc_q[31:ICACHE_IDX_W+2];
    assign fill_idx = addr_q[ICACHE_IDX_W+1:2];
    assign fill_tag = addr_q[31:ICACHE_IDX_W+2];
    assign hit      = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

    assign IF_inst_valid = if_valid_q;
    assign IF_inst       = if_inst_q;
    assign IF_pc         = if_pc_q;
    assign mem_req       = req_q;
    assign mem_addr      = addr_q;

    // Next-state logic: redirect wins, then hit/miss in RUN, refill completion in WAIT; rdy=0 freezes everything
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_inst_d  = if_inst_q;
        if_pc_d    = if_pc_q;
        req_d      = req_q;
        addr_d     = addr_q;
        fill_we    = 1'b0;
        if (rdy) begin
            if_valid_d = 1'b0;
            case (state_q)
                S_RUN: begin
                    if (clear) begin
                        pc_d = jump_pc;
                    end else if (!queue_is_full) begin
                        if (hit) begin
                            if_valid_d = 1'b1;
                            if_inst_d  = data_q[pc_idx];
                            if_pc_d    = pc_q;
                            pc_d       = pc_q + 32'd4;
                        end else begin
                            req_d   = 1'b1;
                            addr_d  = pc_q;
                            state_d = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // A redirect here only moves pc; the refill still lands under its own tag
                    if (mem_done) begin
                        fill_we = 1'b1;
                        req_d   = 1'b0;
                        state_d = S_RUN;
                    end
                    if (clear) begin
                        pc_d = jump_pc;
                    end
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    // Control, output and valid-bit registers with asynchronous reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_RUN;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_inst_q  <= 32'h0;
            if_pc_q    <= 32'h0;
            req_q      <= 1'b0;
            addr_q     <= 32'h0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_inst_q  <= if_inst_d;
            if_pc_q    <= if_pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            if (fill_we) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays need no reset: valid bits gate every lookup
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= mem_data;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        clear = 1'b0;
    logic [31:0] jump_pc = 32'h0;
    logic        queue_is_full = 1'b0;
    logic        mem_done = 1'b0;
    logic [31:0] mem_data = 32'h0;
    logic        IF_inst_valid;
    logic [31:0] IF_inst;
    logic [31:0] IF_pc;
    logic        mem_req;
    logic [31:0] mem_addr;

    int n_checks = 0;
    int n_fail   = 0;

    instruction_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .clear         (clear),
        .jump_pc       (jump_pc),
        .queue_is_full (queue_is_full),
        .IF_inst_valid (IF_inst_valid),
        .IF_inst       (IF_inst),
        .IF_pc         (IF_pc),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_done      (mem_done),
        .mem_data      (mem_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        qf;
        logic        clr;
        logic [31:0] jpc;
        logic        ev;
        logic [31:0] epc;
    } vec_t;

    vec_t tbl [13];

    logic [31:0] line_a [32];
    logic        line_v [32];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        return {~a[15:0], a[15:0]} ^ {a[31:16], 16'h0};
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'(a[6:2]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic serve(input logic [31:0] a);
        mem_done = 1'b1;
        mem_data = word_at(a);
        tick();
        chk("serve req drop", {31'h0, mem_req}, 32'h0);
        chk("serve no strobe", {31'h0, IF_inst_valid}, 32'h0);
        mem_done = 1'b0;
        tick();
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic        done;
        logic        p_rdy, p_qf, p_clr, p_done;
        logic [31:0] p_jump;
        logic        s_valid, s_req;
        logic [31:0] s_pc, s_inst, s_addr;
        logic        req_seen;
        int          lat;
        int          strobes;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h4};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h8};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'hC};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'hC};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 32'h14, 1'b0, 32'h0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h14};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 32'h4,  1'b0, 32'h0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h4};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h8};

        // Reset state
        #3 rst = 1'b0;
        tick();
        tick();
        chk("rst valid", {31'h0, IF_inst_valid}, 32'h0);
        chk("rst inst", IF_inst, 32'h0);
        chk("rst pc", IF_pc, 32'h0);
        chk("rst req", {31'h0, mem_req}, 32'h0);
        chk("rst addr", mem_addr, 32'h0);

        // Cold start: miss at reset pc, word returned after 3 cycles
        rst = 1'b1;
        tick();
        chk("cold req", {31'h0, mem_req}, 32'h1);
        chk("cold addr", mem_addr, 32'h0);
        chk("cold no strobe", {31'h0, IF_inst_valid}, 32'h0);
        tick();
        tick();
        chk("cold req held", {31'h0, mem_req}, 32'h1);
        serve(32'h0);
        chk("cold valid", {31'h0, IF_inst_valid}, 32'h1);
        chk("cold inst", IF_inst, 32'h0000_0013);
        chk("cold pc", IF_pc, 32'h0);

        // Warm lines 0x4..0x1C with an immediate responder
        exp_pc = 32'h4;
        done   = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            tick();
            if (mem_done) mem_done = 1'b0;
            else if (mem_req) begin
                mem_done = 1'b1;
                mem_data = word_at(mem_addr);
            end
            if (IF_inst_valid) begin
                chk("warm pc", IF_pc, exp_pc);
                chk("warm inst", IF_inst, word_at(exp_pc));
                exp_pc = exp_pc + 32'd4;
                if (IF_pc == 32'h1C) begin
                    done          = 1'b1;
                    queue_is_full = 1'b1;
                    clear         = 1'b1;
                    jump_pc       = 32'h0;
                end
            end
        end
        chk("warm reached 0x1c", {31'h0, done}, 32'h1);
        tick();

        // Table: warm loop, back-pressure, rdy stall, redirects
        for (int i = 0; i < 13; i++) begin
            rdy           = tbl[i].r;
            queue_is_full = tbl[i].qf;
            clear         = tbl[i].clr;
            jump_pc       = tbl[i].jpc;
            tick();
            chk($sformatf("tbl%0d valid", i), {31'h0, IF_inst_valid}, {31'h0, tbl[i].ev});
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d pc", i), IF_pc, tbl[i].epc);
                chk($sformatf("tbl%0d inst", i), IF_inst, word_at(tbl[i].epc));
            end
            chk($sformatf("tbl%0d no req", i), {31'h0, mem_req}, 32'h0);
        end
        rdy = 1'b1;
        queue_is_full = 1'b0;
        clear = 1'b0;

        // Aliasing: 0x0 and 0x80 share index 0
        clear = 1'b1; jump_pc = 32'h0;
        tick();
        clear = 1'b0;
        tick();
        chk("alias hit0 valid", {31'h0, IF_inst_valid}, 32'h1);
        chk("alias hit0 pc", IF_pc, 32'h0);
        clear = 1'b1; jump_pc = 32'h80;
        tick();
        clear = 1'b0;
        tick();
        chk("alias miss80 req", {31'h0, mem_req}, 32'h1);
        chk("alias miss80 addr", mem_addr, 32'h80);
        serve(32'h80);
        chk("alias 80 pc", IF_pc, 32'h80);
        chk("alias 80 inst", IF_inst, word_at(32'h80));
        clear = 1'b1; jump_pc = 32'h0;
        tick();
        clear = 1'b0;
        tick();
        chk("alias refetch0 req", {31'h0, mem_req}, 32'h1);
        chk("alias refetch0 addr", mem_addr, 32'h0);
        serve(32'h0);
        chk("alias refetch0 valid", {31'h0, IF_inst_valid}, 32'h1);
        chk("alias refetch0 inst", IF_inst, 32'h0000_0013);

        // Redirect while waiting on 0x20, then clear coincident with mem_done
        clear = 1'b1; jump_pc = 32'h20;
        tick();
        clear = 1'b0;
        tick();
        chk("redir req20", mem_addr, 32'h20);
        clear = 1'b1; jump_pc = 32'h100;
        tick();
        clear = 1'b0;
        chk("redir req held", {31'h0, mem_req}, 32'h1);
        chk("redir addr held", mem_addr, 32'h20);
        tick();
        tick();
        chk("redir still waiting", {31'h0, mem_req}, 32'h1);
        serve(32'h20);
        chk("redir 20 not strobed", {31'h0, IF_inst_valid}, 32'h0);
        chk("redir next req", {31'h0, mem_req}, 32'h1);
        chk("redir next addr", mem_addr, 32'h100);
        clear = 1'b1; jump_pc = 32'h20;
        mem_done = 1'b1; mem_data = word_at(32'h100);
        tick();
        chk("clr+done req drop", {31'h0, mem_req}, 32'h0);
        chk("clr+done no strobe", {31'h0, IF_inst_valid}, 32'h0);
        clear = 1'b0; mem_done = 1'b0;
        tick();
        chk("filled 20 hit valid", {31'h0, IF_inst_valid}, 32'h1);
        chk("filled 20 hit pc", IF_pc, 32'h20);
        chk("filled 20 hit inst", IF_inst, word_at(32'h20));
        chk("filled 20 no req", {31'h0, mem_req}, 32'h0);

        // Asynchronous reset mid-WAIT, then a stray mem_done
        clear = 1'b1; jump_pc = 32'h200;
        tick();
        clear = 1'b0;
        tick();
        chk("areset pre req", {31'h0, mem_req}, 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("areset req drop", {31'h0, mem_req}, 32'h0);
        chk("areset valid drop", {31'h0, IF_inst_valid}, 32'h0);
        chk("areset addr", mem_addr, 32'h0);
        mem_done = 1'b1; mem_data = 32'hDEAD_BEEF;
        #2 rst = 1'b1;
        tick();
        chk("stray req", {31'h0, mem_req}, 32'h1);
        chk("stray addr", mem_addr, 32'h0);
        chk("stray no strobe", {31'h0, IF_inst_valid}, 32'h0);
        mem_done = 1'b0;
        tick();
        chk("stray ignored", {31'h0, mem_req}, 32'h1);
        serve(32'h0);
        chk("post stray inst", IF_inst, 32'h0000_0013);

        // Randomized run against a stream/cache reference model
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 32; i++) line_v[i] = 1'b0;
        exp_pc   = 32'h0;
        req_seen = 1'b0;
        lat      = 0;
        strobes  = 0;
        s_valid = IF_inst_valid; s_pc = IF_pc; s_inst = IF_inst;
        s_req = mem_req; s_addr = mem_addr;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rdy           = ($urandom_range(0, 9) != 0);
            queue_is_full = ($urandom_range(0, 3) == 0);
            clear         = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 5) == 0) jump_pc = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
            else jump_pc = 32'($urandom_range(0, 95)) << 2;
            p_rdy = rdy; p_qf = queue_is_full; p_clr = clear; p_jump = jump_pc; p_done = mem_done;
            tick();
            if (!p_rdy) begin
                chk("rnd hold valid", {31'h0, IF_inst_valid}, {31'h0, s_valid});
                chk("rnd hold pc", IF_pc, s_pc);
                chk("rnd hold inst", IF_inst, s_inst);
                chk("rnd hold req", {31'h0, mem_req}, {31'h0, s_req});
                chk("rnd hold addr", mem_addr, s_addr);
            end else begin
                if (IF_inst_valid) begin
                    strobes++;
                    chk("rnd strobe allowed", {31'h0, p_clr | p_qf | s_req}, 32'h0);
                    chk("rnd pc", IF_pc, exp_pc);
                    chk("rnd inst", IF_inst, word_at(IF_pc));
                    chk("rnd strobe cached", {31'h0, line_v[idx_of(IF_pc)] && line_a[idx_of(IF_pc)] == IF_pc}, 32'h1);
                    exp_pc = exp_pc + 32'd4;
                end
                if (s_req && p_done) begin
                    line_v[idx_of(s_addr)] = 1'b1;
                    line_a[idx_of(s_addr)] = s_addr;
                    chk("rnd fill ends req", {31'h0, mem_req}, 32'h0);
                end else if (s_req) begin
                    chk("rnd req held", {31'h0, mem_req}, 32'h1);
                    chk("rnd addr stable", mem_addr, s_addr);
                end
                if (!s_req && mem_req) begin
                    chk("rnd req addr", mem_addr, exp_pc);
                    chk("rnd req is miss", {31'h0, line_v[idx_of(mem_addr)] && line_a[idx_of(mem_addr)] == mem_addr}, 32'h0);
                    chk("rnd req allowed", {31'h0, p_clr | p_qf}, 32'h0);
                end
                if (p_clr) exp_pc = p_jump;
            end
            s_valid = IF_inst_valid; s_pc = IF_pc; s_inst = IF_inst;
            s_req = mem_req; s_addr = mem_addr;
            if (mem_done && p_rdy) begin
                mem_done = 1'b0;
                req_seen = 1'b0;
            end
            if (mem_req && !req_seen) begin
                req_seen = 1'b1;
                lat      = $urandom_range(0, 3);
            end
            if (req_seen && !mem_done) begin
                if (lat == 0) begin
                    mem_done = 1'b1;
                    mem_data = word_at(mem_addr);
                end else if (p_rdy) begin
                    lat--;
                end
            end
        end
        chk("rnd progress", {31'h0, strobes >= 100}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
